// File: rtl/odd_parity_rx.sv
// Serial frame receiver: start(0), 4 data bits LSB-first, odd parity, stop(1).
// Delivers the nibble with parity/framing flags and keeps a saturating error count.
module odd_parity_rx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sin,
  input  logic                 clr_err,
  output logic [3:0]           data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int H     = CLKS_PER_BIT / 2;
  // The counter is cleared on the sampling edge, so it reads N-1 on the edge N cycles later.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [1:0]             bit_idx_q, bit_idx_d;
  logic [3:0]             shift_q, shift_d;
  logic                   par_bit_q, par_bit_d;
  logic [3:0]             data_out_q, data_out_d;
  logic                   data_valid_q, data_valid_d;
  logic                   parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d;
  logic                   busy_q, busy_d;
  logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    par_bit_d    = par_bit_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!sin) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = 2'd0;
          state_d   = sin ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = sin;
          if (bit_idx_q == 2'd3) state_d = PARITY;
          else                   bit_idx_d = bit_idx_q + 2'd1;
        end
      end
      PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          par_bit_d = sin;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d        = '0;
          data_valid_d = 1'b1;
          data_out_d   = shift_q;
          parity_err_d = ~(^{shift_q, par_bit_q});
          frame_err_d  = ~sin;
          // Returning straight to IDLE lets the very next edge catch a back-to-back start.
          state_d      = sin ? IDLE : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (sin) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);

    // Counts on the cycle data_valid is high; a coincident clear takes priority.
    err_count_d = err_count_q;
    if (clr_err)
      err_count_d = '0;
    else if (data_valid_q && (parity_err_q || frame_err_q) && (err_count_q != '1))
      err_count_d = err_count_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    shift_q   <= shift_d;
    par_bit_q <= par_bit_d;
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
      err_count_q  <= err_count_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_odd_parity_rx.sv
// Directed bench for odd_parity_rx with CLKS_PER_BIT=4 and a 2-bit error counter.
module tb_odd_parity_rx;

  localparam int CPB = 4;
  localparam int ECW = 2;

  logic           clk;
  logic           rst;
  logic           sin;
  logic           clr_err;
  logic [3:0]     data_out;
  logic           data_valid;
  logic           parity_err;
  logic           frame_err;
  logic           busy;
  logic [ECW-1:0] err_count;

  int errors = 0;
  int checks = 0;

  odd_parity_rx #(
    .CLKS_PER_BIT(CPB),
    .ERR_CNT_W   (ECW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .clr_err   (clr_err),
    .data_out  (data_out),
    .data_valid(data_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .busy      (busy),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame; edge idx 0 is the edge that first sees the start bit low.
  // Stop is sampled at edge 2+6*4=26, so data_valid is seen right after edge 26.
  task automatic send_frame(input logic [3:0] d, input logic p, input logic s,
                            input int rst_at, input int clr_at,
                            output int dv_n, output int dv_at,
                            output logic [3:0] d_o, output logic pe, output logic fe);
    logic [6:0] bits;
    int idx;
    bits  = {s, p, d, 1'b0};
    dv_n  = 0;
    dv_at = -1;
    d_o   = 4'h0;
    pe    = 1'b0;
    fe    = 1'b0;
    idx   = 0;
    for (int b = 0; b < 7; b++) begin
      for (int c = 0; c < CPB; c++) begin
        sin     = bits[b];
        rst     = (idx == rst_at);
        clr_err = (idx == clr_at);
        tick();
        rst     = 1'b0;
        clr_err = 1'b0;
        if (idx == rst_at) begin
          check("midrst_data_out", 32'(data_out), 32'h0);
          check("midrst_valid", 32'(data_valid), 32'h0);
          check("midrst_perr", 32'(parity_err), 32'h0);
          check("midrst_ferr", 32'(frame_err), 32'h0);
          check("midrst_busy", 32'(busy), 32'h0);
          check("midrst_errcnt", 32'(err_count), 32'h0);
        end
        if (data_valid) begin
          dv_n++;
          dv_at = idx;
          d_o   = data_out;
          pe    = parity_err;
          fe    = frame_err;
        end
        idx++;
      end
    end
  endtask

  int         dv_n, dv_at, dv_seen;
  logic [3:0] d_o;
  logic       pe, fe;
  logic [ECW-1:0] exp_cnt;

  initial begin
    sin     = 1'b1;
    rst     = 1'b1;
    clr_err = 1'b0;
    tick();
    tick();
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_perr", 32'(parity_err), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_errcnt", 32'(err_count), 32'h0);
    rst = 1'b0;
    tick();
    tick();

    // Good frame 1011, parity 0 (three ones + 0 = odd)
    send_frame(4'b1011, 1'b0, 1'b1, -1, -1, dv_n, dv_at, d_o, pe, fe);
    check("good_dv_count", 32'(dv_n), 32'd1);
    check("good_dv_cycle", 32'(dv_at), 32'd26);
    check("good_data", 32'(d_o), 32'hB);
    check("good_perr", 32'(pe), 32'h0);
    check("good_ferr", 32'(fe), 32'h0);
    check("good_errcnt", 32'(err_count), 32'h0);
    check("good_busy_after", 32'(busy), 32'h0);
    tick();
    tick();
    check("good_data_hold", 32'(data_out), 32'hB);

    // Parity error: 0110 with parity 0 has an even count of ones
    send_frame(4'b0110, 1'b0, 1'b1, -1, -1, dv_n, dv_at, d_o, pe, fe);
    check("perr_data", 32'(d_o), 32'h6);
    check("perr_perr", 32'(pe), 32'h1);
    check("perr_ferr", 32'(fe), 32'h0);
    check("perr_errcnt", 32'(err_count), 32'h1);
    check("perr_flag_hold", 32'(parity_err), 32'h1);
    send_frame(4'b0110, 1'b1, 1'b1, -1, -1, dv_n, dv_at, d_o, pe, fe);
    check("pok_perr", 32'(pe), 32'h0);
    check("pok_errcnt", 32'(err_count), 32'h1);

    // Framing error with stuck-low line: 0011, parity 1 (odd), stop 0
    send_frame(4'b0011, 1'b1, 1'b0, -1, -1, dv_n, dv_at, d_o, pe, fe);
    check("ferr_dv_count", 32'(dv_n), 32'd1);
    check("ferr_data", 32'(d_o), 32'h3);
    check("ferr_perr", 32'(pe), 32'h0);
    check("ferr_ferr", 32'(fe), 32'h1);
    check("ferr_errcnt", 32'(err_count), 32'h2);
    dv_seen = 0;
    for (int i = 0; i < 20; i++) begin
      sin = 1'b0;
      tick();
      if (data_valid) dv_seen++;
    end
    check("stuck_no_dv", 32'(dv_seen), 32'd0);
    check("stuck_busy", 32'(busy), 32'h1);
    sin = 1'b1;
    tick();
    check("stuck_release_busy", 32'(busy), 32'h0);
    tick();
    send_frame(4'b1010, 1'b1, 1'b1, -1, -1, dv_n, dv_at, d_o, pe, fe);
    check("clean_dv_count", 32'(dv_n), 32'd1);
    check("clean_data", 32'(d_o), 32'hA);
    check("clean_perr", 32'(pe), 32'h0);
    check("clean_ferr", 32'(fe), 32'h0);
    check("clean_errcnt", 32'(err_count), 32'h2);

    // False start: one low cycle, line high again before the half-bit sample
    sin = 1'b0;
    tick();
    sin = 1'b1;
    tick();
    check("fstart_busy_mid", 32'(busy), 32'h1);
    tick();
    check("fstart_busy_idle", 32'(busy), 32'h0);
    dv_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (data_valid) dv_seen++;
    end
    check("fstart_no_dv", 32'(dv_seen), 32'd0);
    check("fstart_errcnt", 32'(err_count), 32'h2);

    // Reset during data bit 2 (edge 13); 1111 with parity 1 keeps the line high afterwards
    send_frame(4'b1111, 1'b1, 1'b1, 13, -1, dv_n, dv_at, d_o, pe, fe);
    check("midrst_no_dv", 32'(dv_n), 32'd0);
    send_frame(4'b0101, 1'b1, 1'b1, -1, -1, dv_n, dv_at, d_o, pe, fe);
    check("after_rst_dv", 32'(dv_n), 32'd1);
    check("after_rst_data", 32'(d_o), 32'h5);
    check("after_rst_perr", 32'(pe), 32'h0);
    check("after_rst_ferr", 32'(fe), 32'h0);
    check("after_rst_errcnt", 32'(err_count), 32'h0);

    // Saturation: 0000 with parity 0 is always a parity error
    exp_cnt = '0;
    for (int i = 0; i < 4; i++) begin
      send_frame(4'b0000, 1'b0, 1'b1, -1, -1, dv_n, dv_at, d_o, pe, fe);
      if (exp_cnt != '1) exp_cnt = exp_cnt + 2'd1;
      check($sformatf("sat_errcnt_%0d", i), 32'(err_count), 32'(exp_cnt));
    end
    check("sat_final", 32'(err_count), 32'h3);
    // clr_err at edge 27, the edge where data_valid of this error frame is high
    send_frame(4'b0000, 1'b0, 1'b1, -1, 27, dv_n, dv_at, d_o, pe, fe);
    check("clr_perr", 32'(pe), 32'h1);
    check("clr_wins", 32'(err_count), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/odd_parity_rx.md
Name: odd_parity_rx

Overview:
- Serial frame receiver placed directly upstream of the team's 4-bit odd-parity checker.
- Deserialises an asynchronous-style frame: start bit (0), 4 data bits LSB-first, odd-parity bit, stop bit (1).
- Presents the recovered nibble to the checker stage and flags parity and framing errors.
- Keeps a saturating error counter for status readout.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal range 2..256; half-bit point H = CLKS_PER_BIT/2 (integer divide).
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- sin  input  1  serial line, idle high; already synchronous to clk.
- clr_err  input  1  synchronous clear of err_count.
- data_out  output  4  last received nibble, held until next frame completes.
- data_valid  output  1  one-cycle pulse when a frame completes.
- parity_err  output  1  valid with data_valid; 1 when data+parity has an even number of ones.
- frame_err  output  1  valid with data_valid; 1 when the stop bit was sampled 0.
- busy  output  1  high in every state except IDLE.
- err_count  output  ERR_CNT_W  saturating count of frames with parity_err or frame_err.

Behaviour:
- Reset values: all outputs are 0, state = IDLE, bit/cycle counters = 0. rst wins over all other inputs, including mid-frame; the partial frame is discarded with no data_valid.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE. One shared cycle counter, width $clog2(CLKS_PER_BIT) (min 1). One 2-bit bit index.
- IDLE: sin sampled 0 at an edge (call it cycle 0) -> START, counter cleared.
- START: at cycle H, sample sin.
  - If 1: false start -> IDLE, no output.
  - If 0: -> DATA, bit index 0.
- DATA: data bit k is sampled at cycle H + (k+1)*CLKS_PER_BIT into shift register bit k (LSB-first). After k = 3 -> PARITY.
- PARITY: parity bit sampled at H + 5*CLKS_PER_BIT -> STOP.
- STOP: stop bit sampled at H + 6*CLKS_PER_BIT.
  - If 1 -> IDLE.
  - If 0 -> WAIT_IDLE.
- Outputs on the cycle after the stop sample (cycle H + 6*CLKS_PER_BIT + 1), all registered:
  - data_valid = 1 for exactly one cycle.
  - data_out updated.
  - parity_err = ~(^{data, parity}).
  - frame_err = ~stop.
- data_out, parity_err and frame_err hold their values until the next completed frame.
- WAIT_IDLE: stays until sin = 1, then -> IDLE. This prevents a stuck-low line from being read as back-to-back starts.
- Back-to-back frames: a start edge one cycle after the stop sample must be accepted, i.e. IDLE's first cycle detects it.
- err_count:
  - Increments by 1 in the data_valid cycle if parity_err | frame_err.
  - Saturates at all-ones.
  - clr_err sets it to 0. If clr_err coincides with an increment, the result is 0 (clear wins).
- busy = (state != IDLE), registered with the state.
- Bit sampling is a single sample at the mid-point; no majority vote.

Test Plan:
- Good frame, CLKS_PER_BIT=4, data 4'b1011, parity 0, stop 1; start low at cycle 0.
  -> data bits sampled at cycles 6/10/14/18.
  -> data_valid=1 only at cycle 27, data_out=4'hB, parity_err=0, frame_err=0, err_count=0.
- Parity error: data 4'b0110 sent with parity 0.
  -> data_out=4'h6, parity_err=1, frame_err=0, err_count increments 0->1.
  -> Same data with parity 1 -> parity_err=0.
- Framing error + stuck line: valid frame but stop=0 and sin held low for 20 further cycles.
  -> frame_err=1, state WAIT_IDLE, busy=1, no new frame until sin returns high.
  -> A clean frame afterwards is received correctly.
- False start: sin low for 1 cycle then high (glitch shorter than H).
  -> back to IDLE by cycle H+1, no data_valid, err_count unchanged.
- Reset mid-frame: assert rst during DATA bit 2.
  -> next cycle all outputs 0, busy=0, no data_valid. A following frame 4'h5 (parity 1) is received with no errors.
- Counter saturation and clear, ERR_CNT_W=2: 4 parity-error frames -> err_count 1,2,3,3.
  -> clr_err pulsed in the same cycle as a 5th error's data_valid -> err_count=0.
